preadder_mt: RTL

Valid-gated, multi-thread operand pre-adder for the redundant-polynomial multiplier datapath. It sits in front of the Fp/Fp2 multiplier array and produces the two pre-added operands the multiplier consumes per issue slot. Supported forms are bypass, sum/difference, and cross-round sum or difference against the same thread's previous operands. The block generalises the fixed-thread pre-adder with a parametrised thread count, an in-band valid, a fourth mode, and history that advances only on valid beats, so bubbles in the issue stream do not break thread pairing.

---
 rtl/preadder_mt_pkg.sv | 28 ++
 rtl/preadder_mt_addsub.sv | 28 ++
 rtl/preadder_mt.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/preadder_mt_pkg.sv
// Curve-level constants and types shared by the pre-adder datapath.
package preadder_mt_pkg;

  localparam int L3_NLIMB  = 3;
  localparam int L3_LIMB_W = 64;

  typedef logic [L3_NLIMB*L3_LIMB_W-1:0] redundant_poly_L3;

  // Limbwise redundant multiple of p; keeps A-B non-negative per limb.
  localparam redundant_poly_L3 SUB_BIAS = {64'h0000_0007_FFFF_FFF8,
                                           64'h0000_0007_FFFF_FFF8,
                                           64'h0000_0007_FFFF_FF68};

  typedef enum logic [1:0] {
    PA_BYPASS  = 2'b00,
    PA_SUMDIFF = 2'b01,
    PA_XADD    = 2'b10,
    PA_XSUB    = 2'b11
  } pa_mode_e;

  function automatic logic [L3_LIMB_W-1:0] sub_bias_limb(input int i);
    logic [L3_LIMB_W-1:0] r;
    r = '0;
    if (i >= 0 && i < L3_NLIMB) r = SUB_BIAS[i*L3_LIMB_W +: L3_LIMB_W];
    return r;
  endfunction

endpackage

// File: rtl/preadder_mt_addsub.sv
// Limbwise z = a + b, or z = a + SUB_BIAS + ~b + 1 when sub is set; no carry
// crosses a limb boundary. Purely combinational.
module poly_addsub_limbwise
  import preadder_mt_pkg::*;
#(
  parameter int NLIMB  = 3,
  parameter int LIMB_W = 64
) (
  input  logic [NLIMB*LIMB_W-1:0] a,
  input  logic [NLIMB*LIMB_W-1:0] b,
  input  logic                    sub,
  output logic [NLIMB*LIMB_W-1:0] z
);

  for (genvar i = 0; i < NLIMB; i++) begin : g_limb
    logic [LIMB_W-1:0] al;
    logic [LIMB_W-1:0] bl;
    logic [LIMB_W-1:0] bias;
    logic [LIMB_W-1:0] term;

    assign al   = a[i*LIMB_W +: LIMB_W];
    assign bl   = b[i*LIMB_W +: LIMB_W];
    assign bias = LIMB_W'(sub_bias_limb(i));
    assign term = sub ? (bias + ~bl + LIMB_W'(1)) : bl;
    assign z[i*LIMB_W +: LIMB_W] = al + term;
  end

endmodule

// File: rtl/preadder_mt.sv
// Multi-thread operand pre-adder: bypass, sum/diff, and cross-round add/sub
// against the same thread's previous operands. 2-cycle latency, no backpressure.
module preadder_mt
  import preadder_mt_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int NLIMB     = 3,
  parameter int LIMB_W    = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [1:0]                   mode,
  input  logic [NLIMB*LIMB_W-1:0]      X,
  input  logic [NLIMB*LIMB_W-1:0]      Y,
  output logic                         out_valid,
  output logic [$clog2(N_THREADS)-1:0] out_tid,
  output logic [NLIMB*LIMB_W-1:0]      Z0,
  output logic [NLIMB*LIMB_W-1:0]      Z1
);

  localparam int TW = $clog2(N_THREADS);
  localparam int W  = NLIMB*LIMB_W;

  logic [TW-1:0] tid;
  logic [TW-1:0] cur_tid;
  logic [TW-1:0] nxt_tid;
  logic [W-1:0]  hx [N_THREADS];
  logic [W-1:0]  hy [N_THREADS];
  logic [W-1:0]  prev_x;
  logic [W-1:0]  prev_y;
  pa_mode_e      m;

  logic [W-1:0]  a0_d, b0_d, a1_d, b1_d;
  logic          s0_d, s1_d;

  logic          v1;
  logic [TW-1:0] tid1;
  logic [W-1:0]  a0_q, b0_q, a1_q, b1_q;
  logic          s0_q, s1_q;
  logic [W-1:0]  z0_c, z1_c;

  assign m = pa_mode_e'(mode);

  // A beat coinciding with clear is the first beat of a fresh round.
  always_comb begin
    cur_tid = clear ? '0 : tid;
    prev_x  = clear ? '0 : hx[cur_tid];
    prev_y  = clear ? '0 : hy[cur_tid];
    nxt_tid = (cur_tid == TW'(N_THREADS-1)) ? '0 : cur_tid + TW'(1);
  end

  always_comb begin
    a0_d = X;
    b0_d = '0;
    s0_d = 1'b0;
    a1_d = Y;
    b1_d = '0;
    s1_d = 1'b0;
    case (m)
      PA_BYPASS: ;
      PA_SUMDIFF: begin
        b0_d = Y;
        a1_d = X;
        b1_d = Y;
        s1_d = 1'b1;
      end
      PA_XADD: begin
        b0_d = prev_x;
        b1_d = prev_y;
      end
      PA_XSUB: begin
        b0_d = prev_x;
        s0_d = 1'b1;
        b1_d = prev_y;
        s1_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tid <= '0;
      for (int t = 0; t < N_THREADS; t++) begin
        hx[t] <= '0;
        hy[t] <= '0;
      end
    end else begin
      if (clear) begin
        tid <= '0;
        for (int t = 0; t < N_THREADS; t++) begin
          hx[t] <= '0;
          hy[t] <= '0;
        end
      end
      if (in_valid) begin
        hx[cur_tid] <= X;
        hy[cur_tid] <= Y;
        tid         <= nxt_tid;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      tid1 <= '0;
      a0_q <= '0;
      b0_q <= '0;
      s0_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      s1_q <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        tid1 <= cur_tid;
        a0_q <= a0_d;
        b0_q <= b0_d;
        s0_q <= s0_d;
        a1_q <= a1_d;
        b1_q <= b1_d;
        s1_q <= s1_d;
      end
    end
  end

  poly_addsub_limbwise #(.NLIMB(NLIMB), .LIMB_W(LIMB_W)) u_lane0 (
    .a(a0_q), .b(b0_q), .sub(s0_q), .z(z0_c)
  );

  poly_addsub_limbwise #(.NLIMB(NLIMB), .LIMB_W(LIMB_W)) u_lane1 (
    .a(a1_q), .b(b1_q), .sub(s1_q), .z(z1_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_tid   <= '0;
      Z0        <= '0;
      Z1        <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out_tid <= tid1;
        Z0      <= z0_c;
        Z1      <= z1_c;
      end
    end
  end

endmodule
